// File: rtl/liteic_pkg.sv
// Shared interconnect parameters: address map, channel widths, response codes.
// LITEIC_WR_DECERR_EN selects whether write-path decode misses answer DECERR locally.
package liteic_pkg;

  localparam int IC_AWADDR_WIDTH    = 32;
  localparam int IC_DATA_WIDTH      = 32;
  localparam int IC_STRB_WIDTH      = IC_DATA_WIDTH / 8;
  localparam int IC_WDATA_WIDTH     = IC_STRB_WIDTH + IC_DATA_WIDTH;
  localparam int IC_BRESP_WIDTH     = 2;
  localparam int IC_NUM_SLAVE_SLOTS = 3;
  localparam int IC_SLV_IDX_W       = (IC_NUM_SLAVE_SLOTS > 1) ? $clog2(IC_NUM_SLAVE_SLOTS) : 1;

  // Slot i hits when (addr & MASK[i]) == BASE[i]; index 0 is the rightmost entry.
  localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_AWADDR_WIDTH-1:0] IC_SLAVE_BASE_ADDR =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_AWADDR_WIDTH-1:0] IC_SLAVE_ADDR_MASK =
    {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  localparam logic [IC_SLV_IDX_W-1:0]   IC_LAST_SLOT   = IC_SLV_IDX_W'(IC_NUM_SLAVE_SLOTS - 1);
  localparam logic [IC_BRESP_WIDTH-1:0] IC_RESP_OKAY   = 2'b00;
  localparam logic [IC_BRESP_WIDTH-1:0] IC_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [IC_STRB_WIDTH-1:0] strb;
    logic [IC_DATA_WIDTH-1:0] data;
  } ic_wbeat_t;

  function automatic logic [IC_NUM_SLAVE_SLOTS-1:0] ic_onehot(
    input logic [IC_SLV_IDX_W-1:0] idx, input logic en);
    ic_onehot = IC_NUM_SLAVE_SLOTS'(en) << idx;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle; the write node only touches the aw/w/b channels.
interface axi_lite_if;
  import liteic_pkg::*;

  logic [IC_AWADDR_WIDTH-1:0] aw_addr;
  logic                       aw_valid;
  logic                       aw_ready;
  logic [IC_DATA_WIDTH-1:0]   w_data;
  logic [IC_STRB_WIDTH-1:0]   w_strb;
  logic                       w_valid;
  logic                       w_ready;
  logic [IC_BRESP_WIDTH-1:0]  b_resp;
  logic                       b_valid;
  logic                       b_ready;

  logic [IC_AWADDR_WIDTH-1:0] ar_addr;
  logic                       ar_valid;
  logic                       ar_ready;
  logic [IC_DATA_WIDTH-1:0]   r_data;
  logic [IC_BRESP_WIDTH-1:0]  r_resp;
  logic                       r_valid;
  logic                       r_ready;

  modport wr_slv (input aw_addr, aw_valid, output aw_ready,
                  input w_data, w_strb, w_valid, output w_ready,
                  output b_resp, b_valid, input b_ready);
  modport wr_mst (output aw_addr, aw_valid, input aw_ready,
                  output w_data, w_strb, w_valid, input w_ready,
                  input b_resp, b_valid, output b_ready);
  modport rd_slv (input ar_addr, ar_valid, output ar_ready,
                  output r_data, r_resp, r_valid, input r_ready);
  modport rd_mst (output ar_addr, ar_valid, input ar_ready,
                  input r_data, r_resp, r_valid, output r_ready);
endinterface

// File: rtl/liteic_addr_decoder.sv
// Combinational address-map lookup; the lowest-numbered matching slot wins.
module liteic_addr_decoder
  import liteic_pkg::*;
(
  input  logic [IC_AWADDR_WIDTH-1:0] addr_i,
  output logic [IC_SLV_IDX_W-1:0]    idx_o,
  output logic                       hit_o
);

  // Scanning downward lets the lowest index overwrite any later match.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = IC_NUM_SLAVE_SLOTS - 1; i >= 0; i--) begin
      if ((addr_i & IC_SLAVE_ADDR_MASK[i]) == IC_SLAVE_BASE_ADDR[i]) begin
        hit_o = 1'b1;
        idx_o = IC_SLV_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/liteic_master_node_write.sv
// Write-path master node: one outstanding AW/W/B transaction routed to one slave slot.
// LITEIC_WR_DECERR_EN: decode misses are absorbed locally and answered with DECERR.
module liteic_master_node_write
  import liteic_pkg::*;
#(
  parameter int MST_IDX = 0
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  axi_lite_if.wr_slv                                     mst_axil,
  output logic [IC_AWADDR_WIDTH-1:0]                     cbar_aw_reqst_data_o,
  output logic [IC_NUM_SLAVE_SLOTS-1:0]                  cbar_aw_reqst_val_o,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0]                  cbar_aw_reqst_rdy_i,
  output logic [IC_WDATA_WIDTH-1:0]                      cbar_w_reqst_data_o,
  output logic [IC_NUM_SLAVE_SLOTS-1:0]                  cbar_w_reqst_val_o,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0]                  cbar_w_reqst_rdy_i,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0]                  cbar_resp_val_i,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0][IC_BRESP_WIDTH-1:0] cbar_resp_data_i,
  output logic [IC_NUM_SLAVE_SLOTS-1:0]                  cbar_resp_rdy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
`ifdef LITEIC_WR_DECERR_EN
  localparam logic [1:0] ERR  = 2'd3;
`endif

  logic [1:0]                 state_r;
  logic [IC_AWADDR_WIDTH-1:0] addr_r;
  logic [IC_SLV_IDX_W-1:0]    tgt_r, tgt_d, dec_idx;
  logic                       dec_hit;
  logic                       aw_done_r, w_done_r;
  logic                       rdy_en_r;
  logic                       aw_v, w_v, r_v;
  logic                       aw_hs, w_hs, b_hs, aw_fin, w_fin;
  ic_wbeat_t                  wbeat;

  liteic_addr_decoder u_dec (
    .addr_i (mst_axil.aw_addr),
    .idx_o  (dec_idx),
    .hit_o  (dec_hit)
  );

`ifdef LITEIC_WR_DECERR_EN
  assign tgt_d = dec_hit ? dec_idx : '0;
`else
  assign tgt_d = dec_hit ? dec_idx : IC_LAST_SLOT;
`endif

  assign aw_hs  = mst_axil.aw_valid & mst_axil.aw_ready;
  assign w_hs   = mst_axil.w_valid & mst_axil.w_ready;
  assign b_hs   = mst_axil.b_valid & mst_axil.b_ready;
  assign aw_fin = aw_done_r | cbar_aw_reqst_rdy_i[tgt_r];
  assign w_fin  = w_done_r | w_hs;

  always_comb begin
    mst_axil.aw_ready = rdy_en_r && (state_r == IDLE);
    mst_axil.w_ready  = 1'b0;
    mst_axil.b_valid  = 1'b0;
    mst_axil.b_resp   = IC_RESP_OKAY;
    aw_v              = 1'b0;
    w_v               = 1'b0;
    r_v               = 1'b0;
    case (state_r)
      FWD: begin
        aw_v             = !aw_done_r;
        w_v              = mst_axil.w_valid & !w_done_r;
        mst_axil.w_ready = cbar_w_reqst_rdy_i[tgt_r] & !w_done_r;
      end
      RESP: begin
        mst_axil.b_valid = cbar_resp_val_i[tgt_r];
        mst_axil.b_resp  = cbar_resp_data_i[tgt_r];
        r_v              = mst_axil.b_ready;
      end
`ifdef LITEIC_WR_DECERR_EN
      // The W beat is swallowed here, then the error response is held until taken.
      ERR: begin
        mst_axil.w_ready = !w_done_r;
        mst_axil.b_valid = w_done_r;
        mst_axil.b_resp  = IC_RESP_DECERR;
      end
`endif
      default: ;
    endcase
  end

  assign wbeat                = '{strb: mst_axil.w_strb, data: mst_axil.w_data};
  assign cbar_w_reqst_data_o  = wbeat;
  assign cbar_aw_reqst_data_o = addr_r;
  assign cbar_aw_reqst_val_o  = ic_onehot(tgt_r, aw_v);
  assign cbar_w_reqst_val_o   = ic_onehot(tgt_r, w_v);
  assign cbar_resp_rdy_o      = ic_onehot(tgt_r, r_v);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      tgt_r     <= '0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      rdy_en_r  <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      case (state_r)
        IDLE: if (aw_hs) begin
          addr_r    <= mst_axil.aw_addr;
          tgt_r     <= tgt_d;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
`ifdef LITEIC_WR_DECERR_EN
          state_r   <= dec_hit ? FWD : ERR;
`else
          state_r   <= FWD;
`endif
        end
        FWD: begin
          aw_done_r <= aw_fin;
          w_done_r  <= w_fin;
          if (aw_fin && w_fin) state_r <= RESP;
        end
        RESP: if (b_hs) state_r <= IDLE;
`ifdef LITEIC_WR_DECERR_EN
        ERR: begin
          if (w_hs) w_done_r <= 1'b1;
          if (b_hs) state_r <= IDLE;
        end
`endif
        default: state_r <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(cbar_aw_reqst_val_o) && $onehot0(cbar_w_reqst_val_o) &&
              $onehot0(cbar_resp_rdy_o))
        else $error("liteic_master_node_write[%0d]: crossbar one-hot violated", MST_IDX);
    end
  end

endmodule

// File: tb/tb_liteic_master_node_write.sv
// Directed plus randomized checks of the write node against a slot-map reference model.
module tb_liteic_master_node_write;
  import liteic_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] aw_data;
  logic [2:0]  aw_val, aw_rdy, w_val, w_rdy, resp_val, resp_rdy;
  logic [35:0] w_data;
  logic [2:0][1:0] resp_data;

  int checks = 0;
  int errors = 0;

  axi_lite_if mst ();

  liteic_master_node_write #(.MST_IDX(0)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .mst_axil             (mst),
    .cbar_aw_reqst_data_o (aw_data),
    .cbar_aw_reqst_val_o  (aw_val),
    .cbar_aw_reqst_rdy_i  (aw_rdy),
    .cbar_w_reqst_data_o  (w_data),
    .cbar_w_reqst_val_o   (w_val),
    .cbar_w_reqst_rdy_i   (w_rdy),
    .cbar_resp_val_i      (resp_val),
    .cbar_resp_data_i     (resp_data),
    .cbar_resp_rdy_o      (resp_rdy)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i); #1;
  endtask

  // Reference address map, written directly from the slot table.
  function automatic int exp_slot(input logic [31:0] a);
    case (a[31:16])
      16'h1000: return 0;
      16'h2000: return 1;
      16'h3000: return 2;
      default:  return -1;
    endcase
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_off, input bit rnd);
    int s, aw_start, w_start, aw_cnt[3], w_cnt[3];
    logic [31:0] aw_seen[3];
    logic [35:0] w_seen[3];
    logic [2:0]  mask;
    logic [1:0]  exp_resp, got_resp;
    bit aw_pend, w_pend, aw_acc, b_got;
    s = exp_slot(addr);
    for (int i = 0; i < 3; i++) begin
      aw_cnt[i] = 0; w_cnt[i] = 0; aw_seen[i] = '0; w_seen[i] = '0;
    end
    resp_data = 6'($urandom);
    if (s < 0) begin
`ifdef LITEIC_WR_DECERR_EN
      exp_resp = 2'b11;
`else
      s = 2;
`endif
    end
    if (s >= 0) exp_resp = resp_data[s];
    mask     = (s >= 0) ? 3'(1 << s) : 3'b000;
    aw_start = (w_off < 0) ? -w_off : 0;
    w_start  = (w_off < 0) ? 0 : w_off;
    aw_pend = 1; w_pend = 1; aw_acc = 0; b_got = 0; got_resp = 'x;
    for (int c = 0; c < 200 && !b_got; c++) begin
      mst.aw_addr  = addr;
      mst.aw_valid = aw_pend && (c >= aw_start);
      mst.w_data   = data;
      mst.w_strb   = strb;
      mst.w_valid  = w_pend && (c >= w_start);
      mst.b_ready  = rnd ? 1'($urandom) : 1'b1;
      aw_rdy   = rnd ? 3'($urandom) : 3'b111;
      w_rdy    = rnd ? 3'($urandom) : 3'b111;
      resp_val = rnd ? 3'($urandom) : 3'b111;
      @(negedge clk_i);
      chk("aw_nontgt", 64'(aw_val & ~mask), 64'd0);
      chk("w_nontgt", 64'(w_val & ~mask), 64'd0);
      if (mst.w_valid && !aw_acc) chk("w_rdy_before_aw", 64'(mst.w_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
        if (aw_val[i] && aw_rdy[i]) begin aw_cnt[i]++; aw_seen[i] = aw_data; end
        if (w_val[i] && w_rdy[i]) begin w_cnt[i]++; w_seen[i] = w_data; end
      end
      if (mst.aw_valid && mst.aw_ready) begin aw_pend = 0; aw_acc = 1; end
      if (mst.w_valid && mst.w_ready) w_pend = 0;
      if (mst.b_valid && mst.b_ready) begin b_got = 1; got_resp = mst.b_resp; end
      nxt();
    end
    mst.aw_valid = 0; mst.w_valid = 0;
    chk("b_done", 64'(b_got), 64'd1);
    chk("b_resp", 64'(got_resp), 64'(exp_resp));
    for (int i = 0; i < 3; i++) begin
      chk("aw_beats", 64'(aw_cnt[i]), 64'(i == s));
      chk("w_beats", 64'(w_cnt[i]), 64'(i == s));
      if (i == s) begin
        chk("aw_addr", 64'(aw_seen[i]), 64'(addr));
        chk("w_beat", 64'(w_seen[i]), 64'({strb, data}));
      end
    end
  endtask

  initial begin
    mst.aw_addr = '0; mst.aw_valid = 0; mst.w_data = '0; mst.w_strb = '0;
    mst.w_valid = 0; mst.b_ready = 0;
    mst.ar_addr = '0; mst.ar_valid = 0; mst.ar_ready = 0; mst.r_data = '0;
    mst.r_resp = '0; mst.r_valid = 0; mst.r_ready = 0;
    aw_rdy = '0; w_rdy = '0; resp_val = '0; resp_data = '0;

    // Reset state
    repeat (2) nxt();
    mst.aw_valid = 1; mst.aw_addr = 32'h1000_0000; mst.w_valid = 1;
    aw_rdy = '1; w_rdy = '1; resp_val = '1;
    @(negedge clk_i);
    chk("rst_aw_ready", 64'(mst.aw_ready), 64'd0);
    chk("rst_w_ready", 64'(mst.w_ready), 64'd0);
    chk("rst_b_valid", 64'(mst.b_valid), 64'd0);
    chk("rst_cbar", 64'({aw_val, w_val, resp_rdy}), 64'd0);
    chk("rst_aw_data", 64'(aw_data), 64'd0);
    nxt();
    mst.aw_valid = 0; mst.w_valid = 0;
    rst_i = 0;
    @(negedge clk_i);
    chk("aw_ready_hold", 64'(mst.aw_ready), 64'd0);
    nxt();
    @(negedge clk_i);
    chk("aw_ready_rise", 64'(mst.aw_ready), 64'd1);
    nxt();

    // Slot 2 base, W one cycle behind AW, all readies high
    resp_data = 6'b00_01_01; mst.b_ready = 1;
    mst.aw_addr = 32'h3000_0000; mst.aw_valid = 1;
    @(negedge clk_i);
    chk("t0_aw_ready", 64'(mst.aw_ready), 64'd1);
    nxt();
    mst.aw_valid = 0; mst.w_valid = 1; mst.w_data = 32'h1234_5678; mst.w_strb = 4'h3;
    @(negedge clk_i);
    chk("t1_aw_val", 64'(aw_val), 64'b100);
    chk("t1_w_val", 64'(w_val), 64'b100);
    chk("t1_w_ready", 64'(mst.w_ready), 64'd1);
    chk("t1_aw_data", 64'(aw_data), 64'h3000_0000);
    chk("t1_w_data", 64'(w_data), 64'h3_1234_5678);
    nxt();
    mst.w_valid = 0;
    @(negedge clk_i);
    chk("t2_b_valid", 64'(mst.b_valid), 64'd1);
    chk("t2_b_resp", 64'(mst.b_resp), 64'd0);
    chk("t2_resp_rdy", 64'(resp_rdy), 64'b100);
    chk("t2_aw_val", 64'(aw_val), 64'd0);
    nxt();
    @(negedge clk_i);
    chk("t3_aw_ready", 64'(mst.aw_ready), 64'd1);
    chk("t3_b_valid", 64'(mst.b_valid), 64'd0);
    nxt();

    // W presented before AW
    do_write(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, -2, 0);

    // Slot 1 AW ready held low for 5 cycles; other slots' ready high must be ignored
    aw_rdy = 3'b101; w_rdy = '1; resp_val = '1; resp_data = 6'b11_00_11; mst.b_ready = 1;
    mst.aw_addr = 32'h2000_0040; mst.aw_valid = 1;
    nxt();
    mst.aw_valid = 0; mst.w_valid = 1; mst.w_data = 32'hA5A5_0001; mst.w_strb = 4'h1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("stall_aw_val", 64'(aw_val), 64'b010);
      chk("stall_b_valid", 64'(mst.b_valid), 64'd0);
      if (c == 1) chk("stall_w_val", 64'(w_val), 64'd0);
      nxt();
      mst.w_valid = 0;
    end
    aw_rdy = '1;
    @(negedge clk_i);
    chk("release_aw_val", 64'(aw_val), 64'b010);
    nxt();
    @(negedge clk_i);
    chk("release_aw_once", 64'(aw_val), 64'd0);
    chk("release_b_valid", 64'(mst.b_valid), 64'd1);
    chk("release_b_resp", 64'(mst.b_resp), 64'd0);
    nxt();

    // Decode edges and an unmapped address
    do_write(32'h1000_FFFC, 32'h0BAD_F00D, 4'hC, 0, 0);
    do_write(32'h1001_0000, 32'h7777_0000, 4'h5, 1, 0);
    do_write(32'h4000_0000, 32'hCAFE_0000, 4'hF, 0, 0);

    // Reset pulse while B is being withheld by the master
    aw_rdy = '1; w_rdy = '1; resp_val = '1; resp_data = 6'b00_00_01; mst.b_ready = 0;
    mst.aw_addr = 32'h1000_0100; mst.aw_valid = 1;
    nxt();
    mst.aw_valid = 0; mst.w_valid = 1; mst.w_data = 32'h1111_2222; mst.w_strb = 4'hF;
    nxt();
    mst.w_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("hold_b_valid", 64'(mst.b_valid), 64'd1);
      chk("hold_resp_rdy", 64'(resp_rdy), 64'd0);
      nxt();
    end
    rst_i = 1;
    @(negedge clk_i);
    chk("midrst_b_valid", 64'(mst.b_valid), 64'd0);
    chk("midrst_cbar", 64'({aw_val, w_val, resp_rdy}), 64'd0);
    chk("midrst_rdy", 64'({mst.aw_ready, mst.w_ready}), 64'd0);
    nxt();
    rst_i = 0; mst.b_ready = 1;
    @(negedge clk_i);
    chk("postrst_b_valid", 64'(mst.b_valid), 64'd0);
    nxt();
    do_write(32'h1000_0200, 32'h3333_4444, 4'hA, 0, 0);

    // Randomized traffic with random stalls and W/AW skew
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 3);
      case (k)
        0: a = 32'h1000_0000 | (32'($urandom) & 32'h0000_FFFC);
        1: a = 32'h2000_0000 | (32'($urandom) & 32'h0000_FFFC);
        2: a = 32'h3000_0000 | (32'($urandom) & 32'h0000_FFFC);
        default: a = 32'h4000_0000 | (32'($urandom) & 32'h0FFF_FFFC);
      endcase
      do_write(a, 32'($urandom), 4'($urandom), $urandom_range(0, 4) - 2, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
